// File: rtl/mul_pipe.sv
// Fixed-latency pipelined integer multiplier with per-stage occupancy for the hazard unit.
// Optional macro MUL_HIGH_EN enables MULH/MULHSU/MULHU; otherwise every op computes MUL.
module mul_pipe #(
    parameter int MUL_DELAY = 5,
    parameter int XLEN      = 32,
    parameter int REG_BITS  = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                valid_in,
    input  logic [XLEN-1:0]     a_in,
    input  logic [XLEN-1:0]     b_in,
    input  logic [REG_BITS-1:0] rd_in,
    input  logic [1:0]          funct_in,
    input  logic                stall_in,
    input  logic                flush_in,
    output logic                valids_out [MUL_DELAY-1],
    output logic                valid_out,
    output logic [REG_BITS-1:0] rd_out,
    output logic [XLEN-1:0]     result_out
);

    // Stage 0 holds raw operands; stages 1..MUL_DELAY-1 hold the finished result.
    logic                valid_q [MUL_DELAY];
    logic [REG_BITS-1:0] rd_q    [MUL_DELAY];
    logic [XLEN-1:0]     res_q   [1:MUL_DELAY-1];
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic [XLEN-1:0]     res_d;

`ifdef MUL_HIGH_EN
    logic [1:0]          funct_q;
    logic [2*XLEN-1:0]   a_w;
    logic [2*XLEN-1:0]   b_w;
    logic [2*XLEN-1:0]   prod;

    // Extending to 2*XLEN and multiplying mod 2^(2*XLEN) matches the XLEN+1-bit signed product.
    always_comb begin
        a_w   = {{XLEN{(funct_q != 2'b11) & a_q[XLEN-1]}}, a_q};
        b_w   = {{XLEN{(funct_q[1] == 1'b0) & b_q[XLEN-1]}}, b_q};
        prod  = a_w * b_w;
        res_d = (funct_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
`else
    logic [1:0]          unused_funct;

    assign unused_funct = funct_in;
    assign res_d        = a_q * b_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: data registers are reset too so no X can reach result_out/rd_out after reset.
            for (int i = 0; i < MUL_DELAY; i++) begin
                valid_q[i] <= 1'b0;
                rd_q[i]    <= '0;
            end
            for (int i = 1; i < MUL_DELAY; i++) begin
                res_q[i] <= '0;
            end
            a_q <= '0;
            b_q <= '0;
`ifdef MUL_HIGH_EN
            funct_q <= 2'b00;
`endif
        end else if (flush_in) begin
            for (int i = 0; i < MUL_DELAY; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (!stall_in) begin
            valid_q[0] <= valid_in;
            rd_q[0]    <= rd_in;
            a_q        <= a_in;
            b_q        <= b_in;
`ifdef MUL_HIGH_EN
            funct_q    <= funct_in;
`endif
            valid_q[1] <= valid_q[0];
            rd_q[1]    <= rd_q[0];
            res_q[1]   <= res_d;
            for (int i = 2; i < MUL_DELAY; i++) begin
                valid_q[i] <= valid_q[i-1];
                rd_q[i]    <= rd_q[i-1];
                res_q[i]   <= res_q[i-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MUL_DELAY - 1; i++) begin
            valids_out[i] = valid_q[i];
        end
    end

    assign valid_out  = valid_q[MUL_DELAY-1];
    assign rd_out     = rd_q[MUL_DELAY-1];
    assign result_out = res_q[MUL_DELAY-1];

endmodule

// File: tb/tb_mul_pipe.sv
// Randomized and directed bench for mul_pipe against a queue-based occupancy/arithmetic model.
// Honours MUL_HIGH_EN the same way as the design.
module tb_mul_pipe;

    localparam int D    = 5;
    localparam int XLEN = 32;
    localparam int RB   = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            valid_in;
    logic [XLEN-1:0] a_in;
    logic [XLEN-1:0] b_in;
    logic [RB-1:0]   rd_in;
    logic [1:0]      funct_in;
    logic            stall_in;
    logic            flush_in;
    logic            valids [D-1];
    logic            valid_out;
    logic [RB-1:0]   rd_out;
    logic [XLEN-1:0] result_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [RB-1:0]   rd;
        logic [XLEN-1:0] res;
        int              stage;
    } op_t;

    op_t inflight [$];

    mul_pipe #(.MUL_DELAY(D), .XLEN(XLEN), .REG_BITS(RB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid_in   (valid_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .rd_in      (rd_in),
        .funct_in   (funct_in),
        .stall_in   (stall_in),
        .flush_in   (flush_in),
        .valids_out (valids),
        .valid_out  (valid_out),
        .rd_out     (rd_out),
        .result_out (result_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference arithmetic straight from the ISA definition using 64-bit integers.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] f);
        logic [63:0] p;
`ifdef MUL_HIGH_EN
        case (f)
            2'b00:   p = {32'b0, a} * {32'b0, b};
            2'b01:   p = 64'(longint'($signed(a)) * longint'($signed(b)));
            2'b10:   p = 64'(longint'($signed(a)) * longint'({32'b0, b}));
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (f == 2'b00) ? p[31:0] : p[63:32];
`else
        logic [1:0] unused_f;
        unused_f = f;
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
`endif
    endfunction

    task automatic compare_outputs();
        logic exp_v;
        for (int k = 0; k < D - 1; k++) begin
            exp_v = 1'b0;
            foreach (inflight[i]) if (inflight[i].stage == k) exp_v = 1'b1;
            check($sformatf("valids_out[%0d]", k), 32'(valids[k]), 32'(exp_v));
        end
        exp_v = (inflight.size() > 0) && (inflight[0].stage == D - 1);
        check("valid_out", 32'(valid_out), 32'(exp_v));
        if (exp_v) begin
            check("rd_out", 32'(rd_out), 32'(inflight[0].rd));
            check("result_out", result_out, inflight[0].res);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare 1 time unit later.
    task automatic cyc(input logic rst_n, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [RB-1:0] rd, input logic [1:0] f, input logic st, input logic fl);
        op_t op;
        reset_n  = rst_n;
        valid_in = v;
        a_in     = a;
        b_in     = b;
        rd_in    = rd;
        funct_in = f;
        stall_in = st;
        flush_in = fl;
        @(posedge clk);
        if (!rst_n || fl) begin
            inflight.delete();
        end else if (!st) begin
            foreach (inflight[i]) inflight[i].stage++;
            while (inflight.size() > 0 && inflight[0].stage >= D) void'(inflight.pop_front());
            if (v) begin
                op.rd    = rd;
                op.res   = ref_mul(a, b, f);
                op.stage = 0;
                inflight.push_back(op);
            end
        end
        #1;
        compare_outputs();
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [RB-1:0] rd,
                         input logic [1:0] f);
        cyc(1'b1, 1'b1, a, b, rd, f, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 32'h0, '0, 2'b00, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        // Reset held two cycles with an op presented: nothing may enter the pipe.
        cyc(1'b0, 1'b1, 32'd9, 32'd9, 5'd3, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'd9, 32'd9, 5'd3, 2'b00, 1'b1, 1'b1);
        check("reset result_out", result_out, 32'h0);
        check("reset rd_out", 32'(rd_out), 32'h0);

        // Single MUL walking through every stage.
        issue(32'd7, 32'd6, 5'd1, 2'b00);
        idle(D);

        // Signed corner cases for each funct encoding.
        issue(32'hFFFF_FFFD, 32'd5, 5'd2, 2'b00);
        issue(32'hFFFF_FFFD, 32'd5, 5'd3, 2'b01);
        issue(32'hFFFF_FFFD, 32'd5, 5'd4, 2'b11);
        issue(32'hFFFF_FFFD, 32'd5, 5'd5, 2'b10);
        idle(D);

        // Back-to-back issue.
        issue(32'd1, 32'd2, 5'd10, 2'b00);
        issue(32'd3, 32'd4, 5'd11, 2'b00);
        issue(32'd5, 32'd6, 5'd12, 2'b00);
        idle(D + 1);

        // Three-cycle stall with the op sitting in stage 2, valid_in asserted and ignored.
        issue(32'd100, 32'd3, 5'd7, 2'b00);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'd8, 32'd8, 5'd9, 2'b00, 1'b1, 1'b0);
        idle(D + 1);

        // Flush with ops in stages 0 and 3 and a new op presented.
        issue(32'd11, 32'd12, 5'd13, 2'b00);
        idle(2);
        issue(32'd14, 32'd15, 5'd14, 2'b00);
        cyc(1'b1, 1'b1, 32'd16, 32'd17, 5'd15, 2'b00, 1'b0, 1'b1);
        idle(D + 1);

        // Randomized traffic mixing issue, stall, flush and the occasional reset.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 99) != 0),
                $urandom_range(0, 1) == 1,
                rand_op(), rand_op(),
                RB'($urandom_range(0, 31)),
                2'($urandom_range(0, 3)),
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 19) == 0);
        end
        idle(D + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
